// File: rtl/wksg_dec.sv
// Line-symbol frame decoder: SYNC-delimited 4-symbol frames feed a 2-entry
// output FIFO with overflow tracking and a wrapping accepted-symbol counter.
module wksg_dec (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       sx,
  input  logic       sy,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [1:0] x_out,
  output logic [1:0] y_out,
  output logic       frame_err,
  output logic       overflow,
  output logic [7:0] sym_cnt
);

  typedef enum logic {HUNT = 1'b0, DATA = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [1:0] beat, beat_nxt;
  logic       is_sync;
  logic       push_req;
  logic       err_nxt;

  logic [3:0] mem [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] count;
  logic       pop, push_ok, full;
  logic [3:0] head;

  // Packs the decoded (x,y) pair as {x[1:0], y[1:0]}.
  function automatic logic [3:0] decode(input logic a, input logic b);
    logic [3:0] code;
    case ({a, b})
      2'b01:   code = 4'b0001;
      2'b10:   code = 4'b0100;
      default: code = 4'b0000;
    endcase
    return code;
  endfunction

  assign is_sync = sx & sy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      beat  <= 2'd0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    push_req  = 1'b0;
    err_nxt   = 1'b0;
    if (in_valid) begin
      if (state == HUNT) begin
        if (is_sync) begin
          state_nxt = DATA;
          beat_nxt  = 2'd0;
        end
      end else if (is_sync) begin
        // A SYNC inside a frame restarts it rather than dropping back to HUNT.
        err_nxt  = 1'b1;
        beat_nxt = 2'd0;
      end else begin
        push_req = 1'b1;
        if (beat == 2'd3) begin
          state_nxt = HUNT;
          beat_nxt  = 2'd0;
        end else begin
          beat_nxt = beat + 2'd1;
        end
      end
    end
  end

  assign full      = (count == 2'd2);
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push_ok   = push_req & (~full | pop);
  assign head      = mem[rd_ptr];
  assign x_out     = out_valid ? head[3:2] : 2'b00;
  assign y_out     = out_valid ? head[1:0] : 2'b00;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= decode(sx, sy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      sym_cnt   <= 8'd0;
    end else begin
      frame_err <= err_nxt;
      if (push_ok) begin
        wr_ptr  <= ~wr_ptr;
        sym_cnt <= sym_cnt + 8'd1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push_ok && !pop)      count <= count + 2'd1;
      else if (!push_ok && pop) count <= count - 2'd1;
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wksg_dec.sv
// Self-checking bench for wksg_dec: directed scenarios then random traffic,
// compared against a queue-based frame model.
module tb_wksg_dec;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       sx = 1'b0;
  logic       sy = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [1:0] x_out, y_out;
  logic       frame_err, overflow;
  logic [7:0] sym_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [3:0] q[$];
  bit         in_frame;
  int         remaining;
  int         m_sym;
  bit         m_ovf;
  bit         m_err;

  wksg_dec dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sx(sx), .sy(sy),
    .out_ready(out_ready), .out_valid(out_valid), .x_out(x_out),
    .y_out(y_out), .frame_err(frame_err), .overflow(overflow),
    .sym_cnt(sym_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] hd;
    hd = (q.size() != 0) ? q[0] : 4'b0000;
    check({tag, ".out_valid"}, 8'(out_valid), 8'(q.size() != 0));
    check({tag, ".x_out"}, 8'(x_out), 8'(hd[3:2]));
    check({tag, ".y_out"}, 8'(y_out), 8'(hd[1:0]));
    check({tag, ".frame_err"}, 8'(frame_err), 8'(m_err));
    check({tag, ".overflow"}, 8'(overflow), 8'(m_ovf));
    check({tag, ".sym_cnt"}, sym_cnt, 8'(m_sym));
  endtask

  // x is 01 only for symbol 10, y is 01 only for symbol 01.
  function automatic logic [3:0] model_decode(input logic a, input logic b);
    return {1'b0, a & ~b, 1'b0, b & ~a};
  endfunction

  // One clock: apply inputs, advance the model across the edge, then check.
  task automatic step(input string tag, input logic iv, input logic a, input logic b,
                      input logic rdy);
    in_valid  = iv;
    sx        = a;
    sy        = b;
    out_ready = rdy;
    if (q.size() != 0 && rdy) void'(q.pop_front());
    m_err = 0;
    if (iv) begin
      if (a && b) begin
        if (in_frame) m_err = 1;
        in_frame  = 1;
        remaining = 4;
      end else if (in_frame) begin
        if (q.size() < 2) begin
          q.push_back(model_decode(a, b));
          m_sym = (m_sym + 1) % 256;
        end else begin
          m_ovf = 1;
        end
        remaining--;
        if (remaining == 0) in_frame = 0;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect, releases after an edge.
  task automatic do_reset(input string tag);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    q.delete();
    in_frame  = 0;
    remaining = 0;
    m_sym     = 0;
    m_ovf     = 0;
    m_err     = 0;
    #1;
    check_all(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] s;
    #2;
    do_reset("reset");

    // V1
    step("v1.s0", 1, 1, 1, 1);
    step("v1.s1", 1, 0, 1, 1);
    step("v1.s2", 1, 1, 0, 1);
    step("v1.s3", 1, 0, 0, 1);
    step("v1.s4", 1, 0, 1, 1);
    step("v1.idle", 0, 0, 0, 1);
    check("v1.sym_cnt", sym_cnt, 8'd4);
    step("v1.hunt", 1, 0, 1, 1);

    // V2
    do_reset("v2.rst");
    step("v2.s0", 1, 1, 0, 1);
    step("v2.s1", 0, 0, 0, 1);
    check("v2.out_valid", 8'(out_valid), 8'd0);
    check("v2.sym_cnt", sym_cnt, 8'd0);

    // V3
    do_reset("v3.rst");
    step("v3.s0", 1, 1, 1, 1);
    step("v3.s1", 1, 0, 0, 1);
    step("v3.s2", 1, 1, 1, 1);
    step("v3.s3", 1, 0, 1, 1);
    step("v3.s4", 1, 0, 1, 1);
    step("v3.s5", 1, 0, 1, 1);
    step("v3.s6", 1, 0, 1, 1);
    step("v3.idle", 0, 0, 0, 1);
    check("v3.sym_cnt", sym_cnt, 8'd5);
    step("v3.hunt", 1, 1, 0, 1);

    // V4 then V5
    do_reset("v4.rst");
    step("v4.s0", 1, 1, 1, 0);
    step("v4.s1", 1, 0, 1, 0);
    step("v4.s2", 1, 1, 0, 0);
    step("v4.s3", 1, 0, 0, 0);
    check("v4.overflow", 8'(overflow), 8'd1);
    check("v4.sym_cnt", sym_cnt, 8'd2);
    step("v4.hold", 0, 0, 0, 0);
    do_reset("v5.rst");
    step("v5.s0", 1, 1, 1, 0);
    step("v5.s1", 1, 1, 0, 0);
    step("v5.s2", 1, 0, 1, 0);
    step("v5.s3", 1, 0, 0, 1);
    check("v5.overflow", 8'(overflow), 8'd0);
    check("v5.sym_cnt", sym_cnt, 8'd3);
    step("v5.drain0", 0, 0, 0, 1);
    step("v5.drain1", 0, 0, 0, 1);

    // V6
    do_reset("v6.rst0");
    step("v6.s0", 1, 1, 1, 0);
    step("v6.s1", 1, 0, 1, 0);
    do_reset("v6.rst1");
    step("v6.s2", 1, 0, 1, 1);
    step("v6.s3", 0, 0, 0, 1);
    check("v6.out_valid", 8'(out_valid), 8'd0);

    // V7
    do_reset("v7.rst");
    for (int f = 0; f < 64; f++) begin
      step("v7.sync", 1, 1, 1, 1);
      for (int k = 0; k < 4; k++) begin
        s = 2'($urandom_range(0, 2));
        step("v7.pay", 1, s[1], s[0], 1);
      end
    end
    step("v7.idle", 0, 0, 0, 1);
    check("v7.sym_cnt", sym_cnt, 8'd0);

    // Random traffic
    do_reset("rnd.rst");
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd.rst");
      end else begin
        s = 2'($urandom_range(0, 3));
        step("rnd", $urandom_range(0, 3) != 0, s[1], s[0], $urandom_range(0, 2) != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
